// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline: opcodes, R-type functs, ALU
// control codes and next-PC select codes.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_J   = 2'b10;

endpackage

// File: rtl/id_stage_regfile.sv
// Two-read, one-write register file with synchronous clear and
// write-first bypass so a same-cycle writeback is visible to decode.
module regfile
    import mips_pkg::*;
#(
    parameter int REG_COUNT = 32,
    localparam int AW = $clog2(REG_COUNT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [31:0]   wd,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [31:0]   rd1,
    output logic [31:0]   rd2
);

    logic [31:0] regs_q [REG_COUNT];
    logic [31:0] regs_d [REG_COUNT];
    logic        wr_en_s;

    assign wr_en_s = we && (wa != {AW{1'b0}});

    // Next-state of the storage array
    always_comb begin
        for (int i = 0; i < REG_COUNT; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en_s) begin
            regs_d[wa] = wd;
        end else begin
            regs_d[wa] = regs_q[wa];
        end
    end

    // Storage flops, cleared on reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < REG_COUNT; i++) begin
            if (reset) begin
                regs_q[i] <= 32'h0000_0000;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read ports: $0 is hard zero, pending write wins over stored value
    always_comb begin
        if (ra1 == {AW{1'b0}}) begin
            rd1 = 32'h0000_0000;
        end else if (wr_en_s && (wa == ra1)) begin
            rd1 = wd;
        end else begin
            rd1 = regs_q[ra1];
        end
        if (ra2 == {AW{1'b0}}) begin
            rd2 = 32'h0000_0000;
        end else if (wr_en_s && (wa == ra2)) begin
            rd2 = wd;
        end else begin
            rd2 = regs_q[ra2];
        end
    end

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: IF/ID register, register file, control decode and
// early branch/jump resolution feeding back to fetch.
module id_stage
    import mips_pkg::*;
#(
    parameter int          REG_COUNT   = 32,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallD,
    input  logic [31:0] InstrF,
    input  logic [31:0] PCPlus4F,
    input  logic        RegWriteW,
    input  logic [4:0]  WriteRegW,
    input  logic [31:0] ResultW,
    input  logic        ForwardAD,
    input  logic        ForwardBD,
    input  logic [31:0] ALUOutM,
    output logic [1:0]  PCSrcD,
    output logic [31:0] PCBranchD,
    output logic [31:0] jumpdst,
    output logic [31:0] RD1D,
    output logic [31:0] RD2D,
    output logic [4:0]  RsD,
    output logic [4:0]  RtD,
    output logic [4:0]  RdD,
    output logic [31:0] SignImmD,
    output logic        RegWriteD,
    output logic        MemtoRegD,
    output logic        MemWriteD,
    output logic        ALUSrcD,
    output logic        RegDstD,
    output logic        BranchD,
    output logic [2:0]  ALUControlD
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pcplus4_q, pcplus4_d;
    logic        flush_s, equal_s, is_beq_s, is_bne_s, is_j_s;
    logic [31:0] cmp_a_s, cmp_b_s;

    assign flush_s = (PCSrcD != PCSRC_SEQ);

    // IF/ID next state: stall holds, and takes priority over flush
    always_comb begin
        if (StallD) begin
            instr_d   = instr_q;
            pcplus4_d = pcplus4_q;
        end else if (flush_s) begin
            instr_d   = RESET_INSTR;
            pcplus4_d = 32'h0000_0000;
        end else begin
            instr_d   = InstrF;
            pcplus4_d = PCPlus4F;
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q   <= RESET_INSTR;
            pcplus4_q <= 32'h0000_0000;
        end else begin
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
        end
    end

    assign RsD = instr_q[25:21];
    assign RtD = instr_q[20:16];
    assign RdD = instr_q[15:11];

    regfile #(.REG_COUNT(REG_COUNT)) u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (RegWriteW),
        .wa    (WriteRegW),
        .wd    (ResultW),
        .ra1   (instr_q[25:21]),
        .ra2   (instr_q[20:16]),
        .rd1   (RD1D),
        .rd2   (RD2D)
    );

    // Control decode; unknown opcodes and functs fall out as a nop
    always_comb begin
        RegWriteD   = 1'b0;
        MemtoRegD   = 1'b0;
        MemWriteD   = 1'b0;
        ALUSrcD     = 1'b0;
        RegDstD     = 1'b0;
        BranchD     = 1'b0;
        ALUControlD = ALU_ADD;
        is_beq_s    = 1'b0;
        is_bne_s    = 1'b0;
        is_j_s      = 1'b0;
        SignImmD    = {{16{instr_q[15]}}, instr_q[15:0]};
        case (instr_q[31:26])
            OP_RTYPE: begin
                case (instr_q[5:0])
                    FUNCT_ADD: begin RegWriteD = 1'b1; RegDstD = 1'b1; ALUControlD = ALU_ADD; end
                    FUNCT_SUB: begin RegWriteD = 1'b1; RegDstD = 1'b1; ALUControlD = ALU_SUB; end
                    FUNCT_AND: begin RegWriteD = 1'b1; RegDstD = 1'b1; ALUControlD = ALU_AND; end
                    FUNCT_OR:  begin RegWriteD = 1'b1; RegDstD = 1'b1; ALUControlD = ALU_OR;  end
                    FUNCT_SLT: begin RegWriteD = 1'b1; RegDstD = 1'b1; ALUControlD = ALU_SLT; end
                    default:   ALUControlD = ALU_ADD;
                endcase
            end
            OP_LW:   begin RegWriteD = 1'b1; MemtoRegD = 1'b1; ALUSrcD = 1'b1; end
            OP_SW:   begin MemWriteD = 1'b1; ALUSrcD = 1'b1; end
            OP_BEQ:  begin BranchD = 1'b1; ALUControlD = ALU_SUB; is_beq_s = 1'b1; end
            OP_BNE:  begin BranchD = 1'b1; ALUControlD = ALU_SUB; is_bne_s = 1'b1; end
            OP_ADDI: begin RegWriteD = 1'b1; ALUSrcD = 1'b1; end
            OP_ORI: begin
                RegWriteD   = 1'b1;
                ALUSrcD     = 1'b1;
                ALUControlD = ALU_OR;
                SignImmD    = {16'h0000, instr_q[15:0]};
            end
            OP_SLTI: begin RegWriteD = 1'b1; ALUSrcD = 1'b1; ALUControlD = ALU_SLT; end
            OP_J:    is_j_s = 1'b1;
            default: ALUControlD = ALU_ADD;
        endcase
    end

    assign cmp_a_s = ForwardAD ? ALUOutM : RD1D;
    assign cmp_b_s = ForwardBD ? ALUOutM : RD2D;
    assign equal_s = (cmp_a_s == cmp_b_s);

    // Next-PC select resolved in decode
    always_comb begin
        if (is_j_s) begin
            PCSrcD = PCSRC_J;
        end else if ((is_beq_s && equal_s) || (is_bne_s && !equal_s)) begin
            PCSrcD = PCSRC_BR;
        end else begin
            PCSrcD = PCSRC_SEQ;
        end
    end

    assign PCBranchD = pcplus4_q + {SignImmD[29:0], 2'b00};
    assign jumpdst   = {pcplus4_q[31:28], instr_q[25:0], 2'b00};

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage with hand-computed expectations.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset, StallD, RegWriteW, ForwardAD, ForwardBD;
    logic [31:0] InstrF, PCPlus4F, ResultW, ALUOutM;
    logic [4:0]  WriteRegW;
    logic [1:0]  PCSrcD;
    logic [31:0] PCBranchD, jumpdst, RD1D, RD2D, SignImmD;
    logic [4:0]  RsD, RtD, RdD;
    logic        RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, BranchD;
    logic [2:0]  ALUControlD;

    int n_checks = 0;
    int n_pass   = 0;

    id_stage dut (
        .clk(clk), .reset(reset), .StallD(StallD), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ALUOutM(ALUOutM),
        .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .jumpdst(jumpdst), .RD1D(RD1D), .RD2D(RD2D),
        .RsD(RsD), .RtD(RtD), .RdD(RdD), .SignImmD(SignImmD), .RegWriteD(RegWriteD),
        .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD), .RegDstD(RegDstD),
        .BranchD(BranchD), .ALUControlD(ALUControlD)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // One clock: inputs are driven and outputs sampled on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; StallD = 1'b0; RegWriteW = 1'b0; ForwardAD = 1'b0; ForwardBD = 1'b0;
        InstrF = 32'h0000_0000; PCPlus4F = 32'h0; ResultW = 32'h0; ALUOutM = 32'h0;
        WriteRegW = 5'd0;
        @(negedge clk);
        step();
        chk("rst_pcsrc", {30'd0, PCSrcD}, 32'h0);
        chk("rst_pcbr", PCBranchD, 32'h0);
        chk("rst_jdst", jumpdst, 32'h0);
        chk("rst_rd1", RD1D, 32'h0);
        chk("rst_rd2", RD2D, 32'h0);
        chk("rst_en", {26'd0, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, BranchD}, 32'h0);
        chk("rst_alu", {29'd0, ALUControlD}, 32'h2);

        // addi $1,$0,5
        reset = 1'b0; InstrF = 32'h2001_0005; PCPlus4F = 32'h4;
        step();
        chk("addi_rt", {27'd0, RtD}, 32'd1);
        chk("addi_imm", SignImmD, 32'd5);
        chk("addi_ctl", {28'd0, RegWriteD, ALUSrcD, MemWriteD, RegDstD}, 32'b1100);
        chk("addi_alu", {29'd0, ALUControlD}, 32'h2);
        chk("addi_pcsrc", {30'd0, PCSrcD}, 32'h0);

        // add $4,$3,$0 with same-cycle writeback of $3
        InstrF = 32'h0060_2020;
        step();
        RegWriteW = 1'b1; WriteRegW = 5'd3; ResultW = 32'hDEAD_BEEF;
        #1;
        chk("byp_rd1", RD1D, 32'hDEAD_BEEF);
        chk("add_rd", {27'd0, RdD}, 32'd4);
        chk("add_regdst", {31'd0, RegDstD}, 32'd1);
        @(negedge clk);
        WriteRegW = 5'd0; ResultW = 32'h1234_5678;
        #1;
        chk("wr0_rd2", RD2D, 32'h0);
        chk("stored_rd1", RD1D, 32'hDEAD_BEEF);
        WriteRegW = 5'd1; ResultW = 32'd7;
        step();
        WriteRegW = 5'd2;
        step();
        RegWriteW = 1'b0;

        // beq $1,$2,+3 taken, then flush
        InstrF = 32'h1022_0003; PCPlus4F = 32'h10;
        step();
        chk("beq_pcsrc", {30'd0, PCSrcD}, 32'h1);
        chk("beq_pcbr", PCBranchD, 32'h1C);
        chk("beq_ctl", {28'd0, BranchD, ALUControlD}, 32'b1110);
        InstrF = 32'h2001_0005; PCPlus4F = 32'h14;
        step();
        chk("beq_flush_rw", {31'd0, RegWriteD}, 32'd0);
        chk("beq_flush_rt", {27'd0, RtD}, 32'd0);
        chk("beq_flush_pc", PCBranchD, 32'h0);

        // bne with equal operands: not taken
        InstrF = 32'h1422_0003; PCPlus4F = 32'h10;
        step();
        chk("bne_pcsrc", {30'd0, PCSrcD}, 32'h0);
        chk("bne_br", {31'd0, BranchD}, 32'd1);

        // j 0x40
        InstrF = 32'h0800_0040; PCPlus4F = 32'h8;
        step();
        chk("j_pcsrc", {30'd0, PCSrcD}, 32'h2);
        chk("j_dst", jumpdst, 32'h100);
        InstrF = 32'h2001_0005; PCPlus4F = 32'hC;
        step();
        chk("j_flush_rw", {31'd0, RegWriteD}, 32'd0);
        chk("j_flush_dst", jumpdst, 32'h0);

        // stall beats flush on a taken branch
        InstrF = 32'h1022_0003; PCPlus4F = 32'h10;
        step();
        StallD = 1'b1; InstrF = 32'h2001_0005; PCPlus4F = 32'h20;
        step();
        chk("stall_pcsrc", {30'd0, PCSrcD}, 32'h1);
        chk("stall_pcbr", PCBranchD, 32'h1C);
        chk("stall_rt", {27'd0, RtD}, 32'd2);
        StallD = 1'b0;
        step();
        chk("unstall_flush", {31'd0, BranchD}, 32'd0);

        // beq $0,$2 with branch-operand forwarding
        InstrF = 32'h1002_0003; PCPlus4F = 32'h10;
        step();
        chk("fwd_none", {30'd0, PCSrcD}, 32'h0);
        ForwardAD = 1'b1; ALUOutM = 32'd7;
        #1;
        chk("fwd_a", {30'd0, PCSrcD}, 32'h1);
        ForwardAD = 1'b0; ForwardBD = 1'b1; ALUOutM = 32'd0;
        #1;
        chk("fwd_b", {30'd0, PCSrcD}, 32'h1);
        ForwardBD = 1'b0;

        // Remaining opcode / funct decode
        InstrF = 32'h8C22_0004;
        step();
        chk("lw_ctl", {28'd0, RegWriteD, MemtoRegD, ALUSrcD, MemWriteD}, 32'b1110);
        InstrF = 32'hAC22_0004;
        step();
        chk("sw_ctl", {28'd0, RegWriteD, MemtoRegD, ALUSrcD, MemWriteD}, 32'b0011);
        InstrF = 32'h3422_8001;
        step();
        chk("ori_imm", SignImmD, 32'h0000_8001);
        chk("ori_alu", {29'd0, ALUControlD}, 32'h1);
        InstrF = 32'h2822_FFFF;
        step();
        chk("slti_imm", SignImmD, 32'hFFFF_FFFF);
        chk("slti_alu", {29'd0, ALUControlD}, 32'h7);
        InstrF = 32'h0022_1822;
        step();
        chk("sub_alu", {29'd0, ALUControlD}, 32'h6);
        InstrF = 32'h0022_182A;
        step();
        chk("slt_alu", {29'd0, ALUControlD}, 32'h7);
        InstrF = 32'h0022_1821;
        step();
        chk("badfunct", {28'd0, RegWriteD, RegDstD, ALUControlD[1:0]}, 32'b0010);
        InstrF = 32'hFC00_0000;
        step();
        chk("badop_en", {26'd0, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, BranchD}, 32'h0);
        chk("badop_alu", {29'd0, ALUControlD}, 32'h2);

        // Negative branch offset wraps below PCPlus4D
        InstrF = 32'h1022_FFFF; PCPlus4F = 32'h8;
        step();
        chk("neg_imm", SignImmD, 32'hFFFF_FFFF);
        chk("neg_pcbr", PCBranchD, 32'h4);

        // Reset during a stall clears IF/ID and the register file
        StallD = 1'b1; reset = 1'b1;
        step();
        chk("rst_stall_br", {31'd0, BranchD}, 32'd0);
        chk("rst_stall_pc", PCBranchD, 32'h0);
        reset = 1'b0; StallD = 1'b0; InstrF = 32'h0022_1820; PCPlus4F = 32'h4;
        step();
        chk("rst_rf_rd1", RD1D, 32'h0);
        chk("rst_rf_rd2", RD2D, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
